// File: rtl/score_ctrl_pkg.sv
// Shared definitions for the scored-play session controller.
// Holds the session state encoding and the default sizing/timing values
// that the display mux and the top level also rely on.
package score_ctrl_pkg;

  typedef enum logic [1:0] {
    SC_IDLE   = 2'd0,
    SC_PLAY   = 2'd1,
    SC_SETTLE = 2'd2,
    SC_SHOW   = 2'd3
  } sc_state_e;

  localparam int DEF_SCORE_W      = 14;
  localparam int DEF_ERR_W        = 8;
  localparam int DEF_MISS_PENALTY = 200;
  localparam int DEF_SHOW_CYCLES  = 100_000_000;  // 1 s at 100 MHz
  localparam int DEF_CNT_W        = 27;
  localparam int NOTE_CNT_W       = 10;

endpackage

// File: rtl/score_ctrl_sat_add.sv
// Unsigned saturating adder (combinational).
// Ports:
//   a, b : W-bit unsigned operands
//   y    : a + b, clamped to all-ones when the true sum overflows W bits
module score_ctrl_sat_add #(
  parameter int W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign y   = sum[W] ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/score_ctrl.sv
// Session controller for scored play mode.
// Clears the score on start, accumulates a saturating penalty from judged
// notes, then holds the result phase so the display shows the level.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   start        : pulse, begin a session (IDLE only)
//   abort        : level, cancel an active session, clears score
//   note_valid   : pulse, one judged note; note_miss / note_err qualify it
//   song_done    : pulse, last note judged, enter result phase
//   score        : accumulated penalty (larger = worse), to score2level
//   note_cnt     : notes judged this session, saturating
//   busy         : session active (PLAY, SETTLE, SHOW)
//   show_level   : result being displayed (SHOW)
//   done         : one-cycle pulse on normal SHOW -> IDLE completion
//
// state  | meaning
// IDLE   | no session; score/note_cnt hold last result
// PLAY   | accumulating penalties from judged notes
// SETTLE | one-cycle gap; loads the show timer
// SHOW   | level displayed; timer counts down to 0
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int                 SCORE_W      = DEF_SCORE_W,
  parameter int                 ERR_W        = DEF_ERR_W,
  parameter logic [SCORE_W-1:0] MISS_PENALTY = SCORE_W'(DEF_MISS_PENALTY),
  parameter int                 SHOW_CYCLES  = DEF_SHOW_CYCLES,
  parameter int                 CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  note_valid,
  input  logic                  note_miss,
  input  logic [ERR_W-1:0]      note_err,
  input  logic                  song_done,
  output logic [SCORE_W-1:0]    score,
  output logic [NOTE_CNT_W-1:0] note_cnt,
  output logic                  busy,
  output logic                  show_level,
  output logic                  done
);

  sc_state_e             state, state_nx;
  logic [SCORE_W-1:0]    score_nx;
  logic [NOTE_CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0]      timer, timer_nx;
  logic                  done_nx;

  logic [SCORE_W-1:0]    penalty;
  logic [SCORE_W-1:0]    score_sum;

  assign penalty = note_miss ? MISS_PENALTY
                             : {{(SCORE_W-ERR_W){1'b0}}, note_err};

  score_ctrl_sat_add #(.W(SCORE_W)) u_sat_add (
    .a (score),
    .b (penalty),
    .y (score_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SC_IDLE;
      score      <= '0;
      note_cnt   <= '0;
      timer      <= '0;
      busy       <= 1'b0;
      show_level <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      score      <= score_nx;
      note_cnt   <= cnt_nx;
      timer      <= timer_nx;
      busy       <= (state_nx != SC_IDLE);
      show_level <= (state_nx == SC_SHOW);
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    score_nx = score;
    cnt_nx   = note_cnt;
    timer_nx = timer;
    done_nx  = 1'b0;

    // abort outranks everything, but only once a session is running
    if (abort && (state != SC_IDLE)) begin
      state_nx = SC_IDLE;
      score_nx = '0;
      cnt_nx   = '0;
      timer_nx = '0;
    end else begin
      case (state)
        SC_IDLE: begin
          if (start) begin
            state_nx = SC_PLAY;
            score_nx = '0;
            cnt_nx   = '0;
          end
        end
        SC_PLAY: begin
          // a note arriving alongside song_done still counts
          if (note_valid) begin
            score_nx = score_sum;
            cnt_nx   = (note_cnt == {NOTE_CNT_W{1'b1}}) ? note_cnt
                                                        : note_cnt + NOTE_CNT_W'(1);
          end
          if (song_done) state_nx = SC_SETTLE;
        end
        SC_SETTLE: begin
          timer_nx = CNT_W'(SHOW_CYCLES - 1);
          state_nx = SC_SHOW;
        end
        SC_SHOW: begin
          if (timer == '0) begin
            state_nx = SC_IDLE;
            done_nx  = 1'b1;
          end else begin
            timer_nx = timer - CNT_W'(1);
          end
        end
        default: state_nx = SC_IDLE;
      endcase
    end
  end

endmodule
